// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory-stage responder.
// Used by mem_responder and mem_responder_ram.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int LAT_MAX = 15;
    localparam int LAT_W   = $clog2(LAT_MAX + 1);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Word RAM behind the responder: synchronous write, asynchronous read.
// Contents are not cleared by reset.
module mem_responder_ram
    import mem_responder_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding data-memory responder with fixed response latency.
// Optional perf counters enabled by MEM_RESPONDER_PERF_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              stall
`ifdef MEM_RESPONDER_PERF_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
    output logic [31:0]       stall_count
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   addr_q, addr_d;
    logic               we_q, we_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    logic               req_err;
    logic               in_resp;
    logic               ram_we;
    logic [DATA_W-1:0]  ram_rdata;

    // Misaligned or beyond the RAM's byte range.
    assign req_err = (req_addr[1:0] != 2'b00)
                   | (|req_addr[ADDR_W-1:IDX_W+2]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr[IDX_W+1:2];
                    we_d    = req_we;
                    err_d   = req_err;
                    wdata_d = req_wdata;
                    cnt_d   = LAT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - LAT_W'(1);
                if (cnt_q == LAT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_resp = (state_q == RESP);

    // Write commits on the response edge only, so reset can still cancel it.
    assign ram_we = in_resp & we_q & ~err_q & ~reset;

    mem_responder_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = in_resp;
    assign rsp_err   = in_resp & err_q;
    assign rsp_rdata = (in_resp & ~we_q & ~err_q) ? ram_rdata : '0;
    assign stall     = ((state_q == IDLE) & req_valid) | (state_q == WAIT);

`ifdef MEM_RESPONDER_PERF_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic [31:0] st_cnt_q, st_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        st_cnt_d = st_cnt_q;
        if (in_resp & ~err_q & ~we_q) begin
            rd_cnt_d = sat_inc(rd_cnt_q);
        end
        if (in_resp & ~err_q & we_q) begin
            wr_cnt_d = sat_inc(wr_cnt_q);
        end
        if (stall) begin
            st_cnt_d = sat_inc(st_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            st_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            st_cnt_q <= st_cnt_d;
        end
    end

    assign rd_count    = rd_cnt_q;
    assign wr_count    = wr_cnt_q;
    assign stall_count = st_cnt_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: random and directed word traffic
// checked against an array model of the RAM and the latency rules.
module tb_mem_responder;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 64;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              stall;
`ifdef MEM_RESPONDER_PERF_EN
    logic [31:0]       rd_count;
    logic [31:0]       wr_count;
    logic [31:0]       stall_count;
`endif

    mem_responder #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .stall       (stall)
`ifdef MEM_RESPONDER_PERF_EN
        ,
        .rd_count    (rd_count),
        .wr_count    (wr_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem_m [DEPTH];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          win_t = -100;
    bit          hs_chk = 1'b0;
    bit          mon_en = 1'b0;
    int          rd_m = 0;
    int          wr_m = 0;
    int          st_m = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Handshake and idle-output checks against the acceptance window.
    always @(negedge clk) begin
        if (hs_chk && !reset) begin
            chk("stall", stall, (cyc >= win_t && cyc < win_t + LAT));
            chk("req_ready", req_ready, !(cyc > win_t && cyc <= win_t + LAT));
            if (!rsp_valid) begin
                chk("idle_rdata", rsp_rdata, 0);
                chk("idle_err", rsp_err, 0);
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a response appears.
    always @(negedge clk) begin
        if (mon_en) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                total++;
                bad++;
                $display("FAIL rsp_missing due=%0d now=%0d", q[0].due, cyc);
                void'(q.pop_front());
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_spurious cyc=%0d got=1 want=0", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rsp_time", cyc, e.due);
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", rsp_err, e.err);
                end
            end
        end
    end

    function automatic bit addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        rd_m = 0;
        wr_m = 0;
        st_m = 0;
        win_t = -100;
    endtask

    // Issue one request; returns with the DUT idle one cycle after the response.
    task automatic issue(input bit we, input logic [31:0] a,
                         input logic [31:0] d);
        exp_t e;
        bit   er;
        er = addr_err(a);
        req_valid = 1'b1;
        req_we = we;
        req_addr = a;
        req_wdata = d;
        win_t = cyc;
        e.due = cyc + LAT;
        e.err = er;
        e.rdata = (we || er) ? 32'd0 : mem_m[a[7:2]];
        q.push_back(e);
        if (!er && we) mem_m[a[7:2]] = d;
        if (!er && we) wr_m++;
        if (!er && !we) rd_m++;
        st_m += LAT;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            req_valid = (k < LAT) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_we = 1'($urandom);
            req_addr = $urandom;
            req_wdata = $urandom;
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic rand_op();
        int          r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        if (r == 0) a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        else if (r == 1) a = $urandom | 32'h100;
        else a = 32'($urandom_range(0, 63)) << 2;
        issue(1'($urandom), a, $urandom);
        repeat ($urandom_range(0, 3)) tick();
    endtask

    initial begin
        do_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("rst_ready", req_ready, 1);
            chk("rst_stall", stall, 0);
            chk("rst_valid", rsp_valid, 0);
            chk("rst_rdata", rsp_rdata, 0);
            chk("rst_err", rsp_err, 0);
            tick();
        end
        hs_chk = 1'b1;

        for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), $urandom);

        issue(1'b1, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 32'h10, 32'h0);
        issue(1'b0, 32'h13, 32'h0);
        issue(1'b1, 32'h100, 32'h55AA55AA);
        issue(1'b0, 32'h0, 32'h0);
        issue(1'b0, 32'h4, 32'h0);

        for (int i = 0; i < 200; i++) rand_op();

        // Reset while the write is still waiting: write must vanish.
        hs_chk = 1'b0;
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 32'h8;
        req_wdata = 32'h12345678;
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_m = 0;
        wr_m = 0;
        st_m = 0;
        win_t = -100;
        repeat (3) tick();
        hs_chk = 1'b1;
        issue(1'b0, 32'h8, 32'h0);

        // Reset in the response cycle: strobe still seen, write blocked.
        hs_chk = 1'b0;
        begin
            exp_t e;
            e.due = cyc + LAT;
            e.rdata = 32'd0;
            e.err = 1'b0;
            q.push_back(e);
        end
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 32'h8;
        req_wdata = 32'hCAFEF00D;
        for (int k = 1; k < LAT; k++) begin
            tick();
            req_valid = 1'b0;
        end
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_m = 0;
        wr_m = 0;
        st_m = 0;
        win_t = -100;
        repeat (2) tick();
        hs_chk = 1'b1;
        issue(1'b0, 32'h8, 32'h0);

        do_reset();
        issue(1'b0, 32'h20, 32'h0);
        issue(1'b0, 32'h24, 32'h0);
        issue(1'b1, 32'h28, 32'hA5A5A5A5);
        issue(1'b0, 32'h31, 32'h0);
        repeat (2) tick();
`ifdef MEM_RESPONDER_PERF_EN
        chk("rd_count", rd_count, rd_m);
        chk("wr_count", wr_count, wr_m);
        chk("stall_count", stall_count, st_m);
`endif

        repeat (LAT + 2) tick();
        chk("rsp_left", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
